// File: rtl/quanet_ser_pkg.sv
// Shared types and helpers for the quanet serial (8N1) blocks.
package quanet_ser_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

  // Smallest usable clocks-per-bit; smaller requests are clamped up to this
  localparam logic [15:0] SER_MIN_DIV = 16'd16;

  // 2-of-3 majority vote over the sample history
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/quanet_ser_rx_if.sv
// Received-byte stream: valid/ready handshake carrying one byte per transfer.
interface quanet_ser_rx_if;
  logic [7:0] m_data;
  logic       m_vld;
  logic       m_rdy;

  modport master (output m_data, output m_vld, input m_rdy);
  modport slave  (input m_data, input m_vld, output m_rdy);
endinterface

// File: rtl/quanet_ser_fifo.sv
// Small synchronous byte FIFO with a combinational head-of-queue output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module quanet_ser_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_reg;
  logic [AW:0] rd_reg;
  logic [7:0]  mem [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_reg == rd_reg);
  assign full  = (wr_reg[AW] != rd_reg[AW]) && (wr_reg[AW-1:0] == rd_reg[AW-1:0]);
  // A push into a full FIFO is fine when the head leaves on the same edge
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign head  = mem[rd_reg[AW-1:0]];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      logic [7:0] entry_reg;
      // Storage cell gi: written when the write pointer addresses it
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= 8'h00;
        end else if (wr_en && (wr_reg[AW-1:0] == AW'(gi))) begin
          entry_reg <= din;
        end
      end
      assign mem[gi] = entry_reg;
    end
  endgenerate

  // Pointer advance on accepted push / pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg <= '0;
      rd_reg <= '0;
    end else begin
      if (wr_en) wr_reg <= wr_reg + PTR_ONE;
      if (rd_en) rd_reg <= rd_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/quanet_ser_rx.sv
// 8N1 UART receiver: pin synchronizer, mid-bit 3-sample majority voting,
// byte FIFO on a valid/ready stream, sticky framing/overflow flags.
module quanet_ser_rx
  import quanet_ser_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit INVERT     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_rx,
  input  logic [15:0] baud_div,
  input  logic        clr_err,
  output logic        frame_err,
  output logic        ovf_err,
  output logic        brk,
  output logic        busy,
  quanet_ser_rx_if.master m
);
  // Synchronizer resets to the pin level that reads as idle after inversion
  localparam logic SYNC_IDLE = ~INVERT;

  logic [1:0]  sync_reg;
  logic [1:0]  hist_reg;
  logic        line;
  logic [2:0]  h;
  logic        maj;

  rx_state_t   state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] div_reg, div_next;
  logic [7:0]  sh_reg, sh_next;
  logic [2:0]  bit_reg, bit_next;
  logic [15:0] div_eff;
  logic        at_sample;
  logic        push, frame_set, brk_set, ovf_set;

  logic        frame_err_reg, ovf_err_reg, brk_reg;
  logic [7:0]  head;
  logic        fifo_full, fifo_empty, pop;

  // h[0] is the current synced line, h[2] the oldest sample
  assign line      = sync_reg[1] ^ INVERT;
  assign h         = {hist_reg, line};
  assign maj       = maj3(h);
  assign at_sample = (cnt_reg == 16'd0);

  // Two-flop synchronizer and sample history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= {2{SYNC_IDLE}};
      hist_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], ser_rx};
      hist_reg <= {hist_reg[0], line};
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      div_reg   <= SER_MIN_DIV;
      sh_reg    <= 8'h00;
      bit_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      div_reg   <= div_next;
      sh_reg    <= sh_next;
      bit_reg   <= bit_next;
    end
  end

  // Next-state: bit timing, data shift, frame decisions
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    sh_next    = sh_reg;
    bit_next   = bit_reg;
    push       = 1'b0;
    frame_set  = 1'b0;
    brk_set    = 1'b0;
    div_eff    = (baud_div < SER_MIN_DIV) ? SER_MIN_DIV : baud_div;

    if (state_reg inside {START, DATA, STOP}) begin
      cnt_next = at_sample ? (div_reg - 16'd1) : (cnt_reg - 16'd1);
    end

    case (state_reg)
      IDLE: begin
        if (h == 3'b110) begin
          div_next   = div_eff;
          cnt_next   = {1'b0, div_eff[15:1]} - 16'd1;
          state_next = START;
        end
      end
      START: begin
        if (at_sample) begin
          if (!maj) begin
            state_next = DATA;
            bit_next   = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (at_sample) begin
          sh_next  = {maj, sh_reg[7:1]};
          bit_next = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (at_sample) begin
          if (maj) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_set  = 1'b1;
            brk_set    = (sh_reg == 8'h00);
            state_next = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (maj) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  quanet_ser_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sh_reg),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop      = ~fifo_empty & m.m_rdy;
  assign ovf_set  = push & fifo_full & ~pop;
  assign m.m_data = head;
  assign m.m_vld  = ~fifo_empty;

  // Sticky status flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      ovf_err_reg   <= 1'b0;
      brk_reg       <= 1'b0;
    end else begin
      frame_err_reg <= frame_set | (frame_err_reg & ~clr_err);
      ovf_err_reg   <= ovf_set | (ovf_err_reg & ~clr_err);
      brk_reg       <= brk_set;
    end
  end

  assign frame_err = frame_err_reg;
  assign ovf_err   = ovf_err_reg;
  assign brk       = brk_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/quanet_ser_rx.md
# quanet_ser_rx

Asynchronous serial (8N1 UART) receiver for the ser0/ser1 header lines (j3_10, j3_14) that enter the system wrapper. It synchronizes the raw pin and samples each bit mid-period with 3-sample majority voting. Received bytes are buffered in a small FIFO and presented on a valid/ready byte stream, together with sticky framing and overflow status, for the control/CPU side.

## Interface
- `FIFO_DEPTH`, 4 — byte FIFO entries; power of 2, ≥2.
- `INVERT`, 0 — 1 inverts the pin after synchronization. Use it when a board level translator inverts the line.
- `clk` in 1 — system clock; every flop is on this clock.
- `rst` in 1 — synchronous, active-high reset.
- `ser_rx` in 1 — raw asynchronous serial pin; idle high after optional inversion.
- `baud_div` in 16 — clocks per bit.
  - Values below 16 are treated as 16.
  - Latched when a start edge is detected.
- `m_data` out 8 — FIFO head byte.
- `m_vld` out 1 — FIFO not empty.
- `m_rdy` in 1 — consumer accepts; a pop occurs when `m_vld & m_rdy`.
- `clr_err` in 1 — one-cycle pulse; clears both sticky flags.
- `frame_err` out 1 — sticky; a stop bit was sampled low.
- `ovf_err` out 1 — sticky; a good byte was dropped because the FIFO was full.
- `brk` out 1 — one-cycle pulse on a break frame (all bits 0, stop 0).
- `busy` out 1 — receiver state is not IDLE.

## Operation
- **Synchronizer:** 2-flop synchronizer, then optional inversion, feeding a 3-deep sample history `h[2:0]`. Sampled bit value = majority(`h`).
- **IDLE:** a synced 1→0 transition with `h` = 1,1,0 sets t0 (the first cycle the synced line is 0). On this transition:
  - latch `div` = max(`baud_div`, 16);
  - load bit counter `cnt` = floor(`div`/2) − 1;
  - go to START.
- **Sample-point rule:** `cnt` decrements every cycle. A sample occurs at `cnt == 0`, after which `cnt` reloads `div` − 1.
- **START:** at the sample point:
  - majority 0 → DATA, bit index = 0;
  - majority 1 → false start, back to IDLE. No flags change.
- **DATA:** each sample shifts the majority value into `sh[7]` (right shift, LSB first). After bit index 7 → STOP.
- **STOP:** at the sample point:
  - **Majority 1:** push `sh` to the FIFO → IDLE.
  - **Majority 0:** set `frame_err` and discard the byte. If `sh` == 0x00, also pulse `brk`. Go to WAIT_HI.
- **WAIT_HI:** stays until majority(`h`) = 1 → IDLE. This prevents re-triggering inside a break.
- **FIFO:** circular buffer with wr/rd pointers of log2(`FIFO_DEPTH`)+1 bits.
  - Full and empty are decided from the pointer MSB.
  - `m_data` is the combinational read of the head entry.
- **Push with FIFO full:**
  - pop in the same cycle → push accepted, occupancy unchanged;
  - no pop → byte dropped, `ovf_err` set.
- **Flag priority:** `clr_err` and a new flag event in the same cycle → the flag ends set (set wins).
- **`baud_div` changes:** changes mid-frame have no effect until the next start edge.

## Timing
- **Reset values:**
  - synchronizer flops and `h` = 1 (no false start out of reset);
  - state IDLE, `cnt` = 0, `sh` = 0;
  - FIFO empty, so `m_vld` = 0 and `m_data` = 0;
  - `frame_err`, `ovf_err`, `brk`, `busy` = 0.
- **Reset mid-frame:** abandons the frame; no byte is pushed and no flag is set.
- **Pin to synced line:** 2 cycles.
- **Sample points, with d = `div`:**
  - start bit: t0 + floor(d/2);
  - data bit k: t0 + floor(d/2) + (k+1)·d;
  - stop bit: t0 + floor(d/2) + 9·d.
- **Byte delivery:** `m_vld` rises 1 cycle after the stop sample.
- **Error outputs:** `frame_err` and `brk` assert 1 cycle after the stop sample.
- **Pop:** takes effect at the clock edge. With a continuous `m_rdy`, throughput equals the line rate and no bubbles are inserted.
- **`busy`:** high from t0+1 until IDLE is re-entered.

## Structure
- **Package `quanet_ser_pkg`:**
  - state enum: IDLE, START, DATA, STOP, WAIT_HI;
  - constant `SER_MIN_DIV` = 16;
  - function `maj3`.
- **Sub-module `quanet_ser_fifo`:** synchronous FIFO with parameter `DEPTH`, width 8, push/pop/full/empty, and head-of-queue output. The same sub-module is reusable by a future `quanet_ser_tx`.

## Test plan
- **Basic byte:** `baud_div`=16, send 0xA5 8N1.
  - `m_vld` rises at t0+153 with `m_data`=0xA5;
  - `m_rdy`=1 pops it next cycle;
  - `m_vld`=0 afterwards.
- **Glitch rejection:** 3-cycle low pulse on idle line, `baud_div`=16 → START aborts at t0+8; `busy` then low; no `m_vld`; no flags.
- **Overflow:** `FIFO_DEPTH`=4, `m_rdy`=0, send 0x01..0x05.
  - `ovf_err`=1 after the 5th stop sample;
  - draining yields 0x01, 0x02, 0x03, 0x04.
- **Full FIFO with simultaneous pop:** FIFO full, 5th byte arrives with `m_rdy`=1 on the push cycle → no `ovf_err`; drain order ends with 0x05.
- **Break and recovery:** line held low for 20 bit times.
  - `frame_err`=1 and a single `brk` pulse;
  - no byte pushed;
  - after the line returns high, 0x3C received correctly;
  - `clr_err` clears `frame_err`.
- **Minimum divisor, reset mid-frame, `INVERT`:**
  - `baud_div`=5 behaves as 16;
  - `rst` at bit 4 → no output, and the next byte 0x7E is received correctly;
  - `INVERT`=1 with an inverted 0x55 → 0x55.
